// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU width, op codes, port ids.
// Used by alu, alu_rr_grant and alu_arbiter.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SHL     = 3'b001;
  localparam logic [2:0] ALU_SUB     = 3'b010;
  localparam logic [2:0] ALU_ILLEGAL = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SHR     = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  localparam logic PORT_EXEC = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; the illegal op code yields zero.
// Shifts consume the whole B operand, so any amount of 32 or more clears the result.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_result
);

  logic w_big_shift;

  assign w_big_shift = (i_b >= 32'(DATA_W));

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:     o_result = i_a + i_b;
      ALU_SHL:     o_result = w_big_shift ? '0 : (i_a << i_b[4:0]);
      ALU_SUB:     o_result = i_a - i_b;
      ALU_XOR:     o_result = i_a ^ i_b;
      ALU_SHR:     o_result = w_big_shift ? '0 : (i_a >> i_b[4:0]);
      ALU_OR:      o_result = i_a | i_b;
      ALU_AND:     o_result = i_a & i_b;
      ALU_ILLEGAL: o_result = '0;
      default:     o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant. A lone requester always wins; on contention the
// port named by r_prio wins, and r_prio moves to the other port after each accept.
module alu_rr_grant
  import alu_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_can_accept,
  output logic o_grant,
  output logic o_accept
);

  logic r_prio;

  always_comb begin
    o_grant = r_prio;
    if (i_valid0 && !i_valid1)
      o_grant = PORT_EXEC;
    else if (i_valid1 && !i_valid0)
      o_grant = PORT_AUX;
  end

  assign o_accept = i_can_accept && (i_valid0 || i_valid1);

  // Priority only moves on an accept, so idle cycles never reorder the ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_prio <= PORT_EXEC;
    else if (o_accept)
      r_prio <= ~o_grant;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the aux unit (port 1).
// Define ALU_ARB_STATS_EN to add saturating per-port grant counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_sign
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt
`endif
);

  logic              w_can_accept;
  logic              w_grant;
  logic              w_accept;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_alu_result;

  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_resp_result;
  logic              r_resp_zero;
  logic              r_resp_sign;

  // The result register is also the output buffer: a draining response frees it this cycle.
  assign w_can_accept = !r_resp_valid || resp_ready;

  alu_rr_grant u_grant (
    .clk          (clk),
    .rst          (rst),
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_can_accept (w_can_accept),
    .o_grant      (w_grant),
    .o_accept     (w_accept)
  );

  assign req0_ready = !rst && w_can_accept && (w_grant == PORT_EXEC);
  assign req1_ready = !rst && w_can_accept && (w_grant == PORT_AUX);

  assign w_a  = (w_grant == PORT_AUX) ? req1_a  : req0_a;
  assign w_b  = (w_grant == PORT_AUX) ? req1_b  : req0_b;
  assign w_op = (w_grant == PORT_AUX) ? req1_op : req0_op;

  alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_id     <= PORT_EXEC;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_sign   <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid  <= 1'b1;
      r_resp_id     <= w_grant;
      r_resp_result <= w_alu_result;
      r_resp_zero   <= (w_alu_result == '0);
      r_resp_sign   <= w_alu_result[DATA_W-1];
    end else if (resp_ready) begin
      r_resp_valid  <= 1'b0;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp_sign   = r_resp_sign;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant0_cnt;
  logic [CNT_W-1:0] r_grant1_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
    end else if (w_accept) begin
      if (w_grant == PORT_EXEC && r_grant0_cnt != '1)
        r_grant0_cnt <= r_grant0_cnt + 1'b1;
      if (w_grant == PORT_AUX && r_grant1_cnt != '1)
        r_grant1_cnt <= r_grant1_cnt + 1'b1;
    end
  end

  assign grant0_cnt = r_grant0_cnt;
  assign grant1_cnt = r_grant1_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors queue their hand-computed results
// on accept; a monitor pops and compares on every response handshake.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        resp_valid, resp_id, resp_zero, resp_sign;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;
`ifdef ALU_ARB_STATS_EN
  logic [3:0]  grant0_cnt, grant1_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic        id_log[$];
  logic [31:0] exp_res [2];
  int          acc_cnt [2];

  logic        m_prio, m_valid, held;
  logic [34:0] held_val;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_sign   (resp_sign)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant0_cnt  (grant0_cnt),
    .grant1_cnt  (grant1_cnt)
`endif
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  // Monitor + arbitration model; sampled on the falling edge, inputs move at posedge+2.
  initial begin
    exp_t e;
    logic can, win;
    m_prio = 1'b0; m_valid = 1'b0; held = 1'b0; held_val = '0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        m_prio = 1'b0; m_valid = 1'b0; held = 1'b0;
        sb.delete();
      end else begin
        if (resp_valid) begin
          if (held)
            check("resp_hold", {29'd0, resp_id, resp_zero, resp_sign, resp_result}, {29'd0, held_val});
          if (resp_ready) begin
            if (sb.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL resp_unexpected: got id=%0d result=%0h expected no response", resp_id, resp_result);
            end else begin
              e = sb.pop_front();
              check("resp", {29'd0, resp_id, resp_zero, resp_sign, resp_result},
                    {29'd0, e.id, (e.res == 32'd0), e.res[31], e.res});
              id_log.push_back(resp_id);
            end
          end
          held = !resp_ready;
          held_val = {resp_id, resp_zero, resp_sign, resp_result};
        end else begin
          held = 1'b0;
        end
        can = !m_valid || resp_ready;
        if (req0_valid && !req1_valid) win = 1'b0;
        else if (req1_valid && !req0_valid) win = 1'b1;
        else win = m_prio;
        if (req0_valid || req1_valid) begin
          check("req0_ready", {63'd0, req0_ready}, {63'd0, can && !win});
          check("req1_ready", {63'd0, req1_ready}, {63'd0, can && win});
        end
        if (can && (req0_valid || req1_valid)) begin
          sb.push_back('{id: win, res: exp_res[win]});
          acc_cnt[win] = acc_cnt[win] + 1;
          m_prio = ~win;
          m_valid = 1'b1;
        end else if (resp_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic p, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [31:0] exp);
    int start;
    bit done;
    start = acc_cnt[p];
    exp_res[p] = exp;
    if (p == 1'b0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #2;
      if (acc_cnt[p] != start) done = 1'b1;
    end
    if (p == 1'b0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: port %0d op %0d got no accept expected accept within 40 cycles", p, op);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic exp_ids [6];
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #2;
    check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_fields", {29'd0, resp_id, resp_zero, resp_sign, resp_result}, 64'd0);
    check("rst_prio", {63'd0, dut.u_grant.r_prio}, 64'd0);
    rst = 1'b0;
    idle(1);

    // Single request on port 0
    send(1'b0, 32'd5, 32'd7, ALU_ADD, 32'd12);
    check("single_valid", {63'd0, resp_valid}, 64'd1);
    check("single_fields", {29'd0, resp_id, resp_zero, resp_sign, resp_result}, 64'd12);
    check("single_prio", {63'd0, dut.u_grant.r_prio}, 64'd1);
    idle(2);

    // Contention from reset, then continuous alternation
    pulse_reset();
    id_log.delete();
    fork
      send(1'b0, 32'd3, 32'd3, ALU_SUB, 32'd0);
      send(1'b1, 32'hF0, 32'h0F, ALU_XOR, 32'hFF);
    join
    fork
      begin
        send(1'b0, 32'd10, 32'd1, ALU_ADD, 32'd11);
        send(1'b0, 32'd8, 32'd2, ALU_SHL, 32'd32);
      end
      begin
        send(1'b1, 32'd9, 32'd4, ALU_SUB, 32'd5);
        send(1'b1, 32'hC, 32'hA, ALU_AND, 32'd8);
      end
    join
    idle(2);
    check("contention_count", 64'(id_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < id_log.size(); i++)
      check($sformatf("contention_id%0d", i), {63'd0, id_log[i]}, {63'd0, exp_ids[i]});

    // Backpressure: response held, port 1 stalled, then drain+accept in one cycle
    resp_ready = 1'b0;
    send(1'b0, 32'd10, 32'd20, ALU_ADD, 32'd30);
    fork
      send(1'b1, 32'hFF00, 32'h0FF0, ALU_OR, 32'hFFF0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_resp", {30'd0, resp_valid, resp_id, resp_result}, {30'd0, 1'b1, 1'b0, 32'd30});
          check("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
        end
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
      end
    join
    check("bp_next", {30'd0, resp_valid, resp_id, resp_result}, {30'd0, 1'b1, 1'b1, 32'hFFF0});
    idle(2);

    // Edge cases
    send(1'b1, 32'd1, 32'd31, ALU_SHL, 32'h8000_0000);
    send(1'b1, 32'hFFFF_FFFF, 32'd32, ALU_SHR, 32'd0);
    send(1'b1, 32'h1234, 32'h5678, ALU_ILLEGAL, 32'd0);
    send(1'b0, 32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF);
    send(1'b0, 32'h8000_0000, 32'd4, ALU_SHR, 32'h0800_0000);
    idle(2);

    // Asynchronous reset between edges while a response is pending
    resp_ready = 1'b0;
    send(1'b0, 32'd1, 32'd2, ALU_ADD, 32'd3);
    check("midrst_pre_valid", {63'd0, resp_valid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_prio", {63'd0, dut.u_grant.r_prio}, 64'd0);
    check("midrst_fields", {29'd0, resp_id, resp_zero, resp_sign, resp_result}, 64'd0);
    check("midrst_req0_ready", {63'd0, req0_ready}, 64'd0);
    rst = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #2;
    send(1'b0, 32'd100, 32'd23, ALU_ADD, 32'd123);
    check("postrst_resp", {30'd0, resp_valid, resp_id, resp_result}, {30'd0, 1'b1, 1'b0, 32'd123});
    idle(2);

`ifdef ALU_ARB_STATS_EN
    pulse_reset();
    for (int i = 0; i < 20; i++)
      send(1'b0, 32'(i), 32'd1, ALU_ADD, 32'(i + 1));
    idle(2);
    check("grant0_cnt_sat", {60'd0, grant0_cnt}, 64'd15);
    check("grant1_cnt", {60'd0, grant1_cnt}, 64'd0);
`endif

    idle(3);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
